// File: rtl/window_pkg.sv
// ---------------------------------------------------------------------------
// window_pkg
// Shared definitions for the sliding-window generator.
//   DEF_K, DEF_IMG_W, DEF_IMG_H : default window side and image dimensions
//   state_t                     : window generator FSM states
// ---------------------------------------------------------------------------
package window_pkg;

  localparam int DEF_K     = 5;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    EMIT  = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/window_gen_line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image line of pixel storage, DEPTH x WIDTH bits, with a single address
// shared by the write and read ports.
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   addr_i  : read/write address (pixel column)
//   wdata_i : data written at the next rising edge when we_i is high
//   rdata_o : asynchronous read of the current contents at addr_i
// Contents are intentionally not reset.
// ---------------------------------------------------------------------------
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read returns the value from one line ago; the write replaces it at the
  // same edge, which makes the buffer behave as a one-line delay.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen.sv
// ---------------------------------------------------------------------------
// window_gen
// Builds a KxK window around each interior pixel of a raster image and
// serializes it, row-major from the top-left sample, to a median stage.
//
// Parameters: IMG_W, IMG_H (K..255), K (3, 5 or 7)
// Ports:
//   clk_i_window   : clock, rising edge
//   rst_i_window   : synchronous active-high reset
//   frame_start_i  : concurrent/next pixel is row 0, col 0; aborts emission
//   pix_valid_i    : raster pixel valid
//   pix_i          : raster pixel
//   pix_ready_o    : high in FILL; pixel accepted when valid & ready
//   win_start_o    : one-cycle pulse before a window is serialized
//   win_data_o     : serialized window sample (0 when not valid)
//   win_valid_o    : win_data_o valid
//   done_i         : median-stage done pulse, honoured only in WAIT
//   win_row_o/col_o: centre coordinates of the current window
//   busy_o         : high in any state other than FILL
//   window_cnt_o   : emitted-window count
//
// Build option: define WINDOW_CNT_EN to build the 16-bit window counter;
// otherwise window_cnt_o is tied to 0.
// ---------------------------------------------------------------------------
module window_gen
  import window_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K     = DEF_K
) (
  input  logic        clk_i_window,
  input  logic        rst_i_window,
  input  logic        frame_start_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  pix_i,
  output logic        pix_ready_o,
  output logic        win_start_o,
  output logic [7:0]  win_data_o,
  output logic        win_valid_o,
  input  logic        done_i,
  output logic [7:0]  win_row_o,
  output logic [7:0]  win_col_o,
  output logic        busy_o,
  output logic [15:0] window_cnt_o
);

  localparam int HALF = (K - 1) / 2;
  localparam int CW   = $clog2(K);
  localparam int AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  state_t          state_q, state_d;
  logic [7:0]      row_q, row_d;
  logic [7:0]      col_q, col_d;
  logic [7:0]      win_row_q, win_row_d;
  logic [7:0]      win_col_q, win_col_d;
  logic [CW-1:0]   emit_r_q, emit_r_d;
  logic [CW-1:0]   emit_c_q, emit_c_d;

  logic            accept;
  logic [7:0]      cur_row;
  logic [7:0]      cur_col;

  logic [7:0]      lb_wd  [K-1];
  logic [7:0]      lb_rd  [K-1];
  logic [7:0]      col_new [K];
  logic [7:0]      win_q  [K][K];
  logic [7:0]      win_d  [K][K];

  // A frame start takes the concurrent pixel as (0,0) even outside FILL.
  assign accept  = pix_valid_i & ((state_q == FILL) | frame_start_i);
  assign cur_row = frame_start_i ? 8'd0 : row_q;
  assign cur_col = frame_start_i ? 8'd0 : col_q;

  // Line buffer chain: buffer 0 delays the raster by one line, buffer i by
  // i+1 lines, so the reads at the current column give the column above.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      assign lb_wd[i] = pix_i;
    end else begin : g_chain
      assign lb_wd[i] = lb_rd[i-1];
    end
    line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (8),
      .AW    (AW)
    ) u_line_buffer (
      .clk_i   (clk_i_window),
      .we_i    (accept),
      .addr_i  (cur_col[AW-1:0]),
      .wdata_i (lb_wd[i]),
      .rdata_o (lb_rd[i])
    );
  end

  // New right-hand column: oldest line on top, the live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      col_new[r] = 8'd0;
    end
    for (int r = 0; r < K - 1; r++) begin
      col_new[r] = lb_rd[K-2-r];
    end
    col_new[K-1] = pix_i;
  end

  // Window register shifts one column left per accepted pixel.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = col_new[r];
      end
    end
  end

  // Window contents carry no reset; row/col gating hides stale samples.
  always_ff @(posedge clk_i_window) begin
    win_q <= win_d;
  end

  // Raster position tracking and FSM next state.
  always_comb begin
    state_d   = state_q;
    row_d     = cur_row;
    col_d     = cur_col;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    emit_r_d  = emit_r_q;
    emit_c_d  = emit_c_q;

    if (accept) begin
      if (cur_col == 8'(IMG_W - 1)) begin
        col_d = 8'd0;
        row_d = (cur_row == 8'(IMG_H - 1)) ? 8'd0 : cur_row + 8'd1;
      end else begin
        col_d = cur_col + 8'd1;
      end
    end

    case (state_q)
      FILL: begin
        // A full window exists once the pixel at its bottom-right arrives.
        if (accept && (cur_row >= 8'(K - 1)) && (cur_col >= 8'(K - 1))) begin
          state_d   = START;
          win_row_d = cur_row - 8'(HALF);
          win_col_d = cur_col - 8'(HALF);
        end
      end
      START: begin
        state_d  = EMIT;
        emit_r_d = '0;
        emit_c_d = '0;
      end
      EMIT: begin
        if (emit_c_q == CW'(K - 1)) begin
          emit_c_d = '0;
          if (emit_r_q == CW'(K - 1)) begin
            state_d = WAIT;
          end else begin
            emit_r_d = emit_r_q + 1'b1;
          end
        end else begin
          emit_c_d = emit_c_q + 1'b1;
        end
      end
      WAIT: begin
        if (done_i) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (frame_start_i) begin
      state_d  = FILL;
      emit_r_d = '0;
      emit_c_d = '0;
    end
  end

  always_ff @(posedge clk_i_window) begin
    if (rst_i_window) begin
      state_q   <= FILL;
      row_q     <= 8'd0;
      col_q     <= 8'd0;
      win_row_q <= 8'd0;
      win_col_q <= 8'd0;
      emit_r_q  <= '0;
      emit_c_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      emit_r_q  <= emit_r_d;
      emit_c_q  <= emit_c_d;
    end
  end

`ifdef WINDOW_CNT_EN
  logic [15:0] window_cnt_q, window_cnt_d;

  // One count per START cycle; wraps naturally at 16 bits.
  always_comb begin
    window_cnt_d = window_cnt_q;
    if (state_q == START) begin
      window_cnt_d = window_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i_window) begin
    if (rst_i_window) begin
      window_cnt_q <= 16'd0;
    end else begin
      window_cnt_q <= window_cnt_d;
    end
  end

  assign window_cnt_o = window_cnt_q;
`else
  assign window_cnt_o = 16'd0;
`endif

  assign pix_ready_o = (state_q == FILL);
  assign busy_o      = (state_q != FILL);
  assign win_start_o = (state_q == START);
  assign win_valid_o = (state_q == EMIT);
  assign win_data_o  = (state_q == EMIT) ? win_q[emit_r_q][emit_c_q] : 8'd0;
  assign win_row_o   = win_row_q;
  assign win_col_o   = win_col_q;

endmodule
